// File: rtl/cpu_types_pkg.sv
// Shared CPU types: fetch FSM states, the default fetch-queue entry layout and a
// saturating counter helper.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        SQUASH = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {instr, pc} entries with a combinational head; flush beats push/pop
// and reset clears the storage as well as the pointers.
module fetch_queue
    import cpu_types_pkg::*;
#(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    input  logic                   flush,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          mem_reg [DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (do_push && !flush) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, prefetches into fetch_queue, handles
// redirect/squash and halt. Define FETCH_PERF_EN to add saturating perf counters.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter int                WORD_W  = 32,
    parameter logic [WORD_W-1:0] PC_INIT = '0,
    parameter int                DEPTH   = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    output logic                   imemREN,
    output logic [WORD_W-1:0]      imemaddr,
    input  logic [WORD_W-1:0]      imemload,
    input  logic                   ihit,
    input  logic                   redirect,
    input  logic [WORD_W-1:0]      redirect_pc,
    input  logic                   halt,
    input  logic                   stall,
    output logic                   instr_valid,
    output logic [WORD_W-1:0]      instr,
    output logic [WORD_W-1:0]      instr_pc,
    output logic [$clog2(DEPTH):0] q_count
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_squashed,
    output logic [31:0]            perf_qfull
`endif
);

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } entry_t;

    fetch_state_t          state_reg, state_next;
    logic [WORD_W-1:0]     fetch_pc_reg, fetch_pc_next;
    logic [WORD_W-1:0]     target_reg, target_next;
    logic [WORD_W-1:0]     redirect_word;
    logic                  run_reg;
    logic                  hit, push, pop, flush;
    logic                  q_full, q_empty;
    entry_t                head, push_entry;
    logic [$clog2(DEPTH):0] count;

    assign redirect_word = {redirect_pc[WORD_W-1:2], 2'b00};
    assign push_entry    = '{instr: imemload, pc: fetch_pc_reg};

    // run_reg keeps the bus idle for the first cycle after reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= FETCH;
            fetch_pc_reg <= PC_INIT;
            target_reg   <= '0;
            run_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            target_reg   <= target_next;
            run_reg      <= 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        target_next   = target_reg;
        push          = 1'b0;
        flush         = 1'b0;
        if (halt) begin
            state_next = HALTED;
            flush      = 1'b1;
        end else if (state_reg == HALTED) begin
            state_next = HALTED;
        end else if (redirect) begin
            flush = 1'b1;
            if (imemREN && !hit) begin
                // Outstanding beat must still drain before the new target is fetched.
                target_next = redirect_word;
                state_next  = SQUASH;
            end else begin
                fetch_pc_next = redirect_word;
                state_next    = FETCH;
            end
        end else if (state_reg == SQUASH) begin
            if (hit) begin
                fetch_pc_next = target_reg;
                state_next    = FETCH;
            end
        end else if (hit) begin
            push          = 1'b1;
            fetch_pc_next = fetch_pc_reg + WORD_W'(4);
        end
    end

    always_comb begin
        imemREN = 1'b0;
        if (run_reg) begin
            imemREN = (state_reg == SQUASH) || ((state_reg == FETCH) && !q_full);
        end
    end

    assign hit         = imemREN && ihit;
    assign pop         = !q_empty && !stall;
    assign imemaddr    = fetch_pc_reg;
    assign instr_valid = !q_empty;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign q_count     = count;

    fetch_queue #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_queue (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .count     (count),
        .full      (q_full),
        .empty     (q_empty)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_reg, squashed_reg, qfull_reg;
    logic [31:0] squash_inc;

    assign squash_inc = 32'(hit && !push) + (flush ? 32'(count) : 32'd0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetched_reg  <= '0;
            squashed_reg <= '0;
            qfull_reg    <= '0;
        end else begin
            fetched_reg  <= sat_add32(fetched_reg, 32'(push));
            squashed_reg <= sat_add32(squashed_reg, squash_inc);
            qfull_reg    <= sat_add32(qfull_reg, 32'(q_full));
        end
    end

    assign perf_fetched  = fetched_reg;
    assign perf_squashed = squashed_reg;
    assign perf_qfull    = qfull_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit (DEPTH 4), plus a PC wrap check on a
// second instance reset to 0xFFFFFFF8.
module tb_fetch_unit;

    logic        CLK;
    logic        RST, ihit, redirect, halt, stall;
    logic [31:0] imemload, redirect_pc;
    logic        imemREN, instr_valid;
    logic [31:0] imemaddr, instr, instr_pc;
    logic [2:0]  q_count;

    logic        rst2, ihit2;
    logic [31:0] imemload2;
    logic        ren2, valid2;
    logic [31:0] addr2, instr2, pc2;
    logic [2:0]  cnt2;

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit #(.WORD_W(32), .PC_INIT(32'h0), .DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .imemload(imemload), .ihit(ihit), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .stall(stall), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .q_count(q_count)
    );

    fetch_unit #(.WORD_W(32), .PC_INIT(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
        .CLK(CLK), .RST(rst2), .imemREN(ren2), .imemaddr(addr2),
        .imemload(imemload2), .ihit(ihit2), .redirect(1'b0), .redirect_pc(32'h0),
        .halt(1'b0), .stall(1'b0), .instr_valid(valid2), .instr(instr2),
        .instr_pc(pc2), .q_count(cnt2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst, ihit, stall, redir, halt;
        logic [31:0] rpc;
        logic        e_ren;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
        logic        chk_head;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic vec_t v(input logic rst, ihit, stall, redir, halt, input logic [31:0] rpc,
                               input logic ren, input logic [31:0] addr, input logic valid,
                               input logic [31:0] pc, input logic [2:0] cnt, input logic chk);
        vec_t r;
        r.rst = rst; r.ihit = ihit; r.stall = stall; r.redir = redir; r.halt = halt; r.rpc = rpc;
        r.e_ren = ren; r.e_addr = addr; r.e_valid = valid; r.e_pc = pc; r.e_cnt = cnt;
        r.chk_head = chk;
        return r;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    vec_t t;

    initial begin
        RST = 1'b1; ihit = 0; redirect = 0; halt = 0; stall = 0;
        imemload = 0; redirect_pc = 0;
        rst2 = 1'b1; ihit2 = 0; imemload2 = 0;

        //            rst ihit stl rdr hlt rpc          ren addr         vld pc            cnt chk
        // A: streaming, no stall
        tbl.push_back(v(0, 1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1));
        tbl.push_back(v(0, 1, 0, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 32'h0,        1, 32'h4,        1, 32'h0,        1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 32'h0,        1, 32'h8,        1, 32'h4,        1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 32'h0,        1, 32'hC,        1, 32'h8,        1, 0));
        // B: fill under stall, then drain in order
        tbl.push_back(v(0, 1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1));
        tbl.push_back(v(0, 1, 1, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        0, 0));
        tbl.push_back(v(0, 1, 1, 0, 0, 32'h0,        1, 32'h4,        1, 32'h0,        1, 0));
        tbl.push_back(v(0, 1, 1, 0, 0, 32'h0,        1, 32'h8,        1, 32'h0,        2, 0));
        tbl.push_back(v(0, 1, 1, 0, 0, 32'h0,        1, 32'hC,        1, 32'h0,        3, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 32'h0,        0, 32'h10,       1, 32'h0,        4, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,        1, 32'h10,       1, 32'h4,        3, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,        1, 32'h10,       1, 32'h8,        2, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,        1, 32'h10,       1, 32'hC,        1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 32'h0,        1, 32'h10,       0, 32'h0,        0, 0));
        // C: redirect with request outstanding -> SQUASH
        tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1));
        tbl.push_back(v(0, 1, 1, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        0, 0));
        tbl.push_back(v(0, 1, 1, 0, 0, 32'h0,        1, 32'h4,        1, 32'h0,        1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 32'h103,      1, 32'h8,        1, 32'h0,        2, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,        1, 32'h8,        0, 32'h0,        0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,        1, 32'h8,        0, 32'h0,        0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 32'h0,        1, 32'h8,        0, 32'h0,        0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 32'h0,        1, 32'h100,      0, 32'h0,        0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 32'h0,        1, 32'h104,      1, 32'h100,      1, 0));
        // D: redirect with ihit and pending pop in the same cycle
        tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1));
        tbl.push_back(v(0, 1, 0, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 32'h42,       1, 32'h4,        1, 32'h0,        1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 32'h0,        1, 32'h40,       0, 32'h0,        0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 32'h0,        1, 32'h44,       1, 32'h40,       1, 0));
        // E: halt with request outstanding, reset restart, halt beats redirect
        tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1));
        tbl.push_back(v(0, 1, 0, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        0, 0));
        tbl.push_back(v(0, 0, 1, 0, 1, 32'h0,        1, 32'h4,        1, 32'h0,        1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 32'h80,       0, 32'h0,        0, 32'h0,        0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1));
        tbl.push_back(v(0, 0, 0, 1, 1, 32'h200,      1, 32'h0,        0, 32'h0,        0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0));

        repeat (2) @(posedge CLK);
        @(negedge CLK);

        for (int i = 0; i < tbl.size(); i++) begin
            t = tbl[i];
            chk("imemREN", i, {31'b0, imemREN}, {31'b0, t.e_ren});
            if (t.e_ren) chk("imemaddr", i, imemaddr, t.e_addr);
            chk("instr_valid", i, {31'b0, instr_valid}, {31'b0, t.e_valid});
            chk("q_count", i, {29'b0, q_count}, {29'b0, t.e_cnt});
            if (t.e_valid || t.chk_head) begin
                chk("instr_pc", i, instr_pc, t.e_pc);
                chk("instr", i, instr, t.chk_head ? 32'h0 : mem(t.e_pc));
            end
            $display("vec %0d: ren=%b addr=%h valid=%b pc=%h cnt=%0d", i, imemREN, imemaddr,
                     instr_valid, instr_pc, q_count);
            RST = t.rst; ihit = t.ihit; stall = t.stall; redirect = t.redir;
            halt = t.halt; redirect_pc = t.rpc; imemload = mem(imemaddr);
            @(negedge CLK);
        end

        // PC wrap on the second instance.
        chk("wrap_ren_reset", 0, {31'b0, ren2}, 32'h0);
        chk("wrap_cnt_reset", 0, {29'b0, cnt2}, 32'h0);
        rst2 = 1'b0; ihit2 = 1'b1; imemload2 = mem(addr2);
        @(negedge CLK);
        for (int k = 1; k <= 4; k++) begin
            logic [31:0] exp_addr;
            exp_addr = 32'hFFFF_FFF8 + 32'(4 * (k - 1));
            chk("wrap_ren", k, {31'b0, ren2}, 32'h1);
            chk("wrap_addr", k, addr2, exp_addr);
            if (k > 1) begin
                chk("wrap_pc", k, pc2, exp_addr - 32'h4);
                chk("wrap_instr", k, instr2, mem(exp_addr - 32'h4));
            end
            $display("wrap %0d: ren=%b addr=%h valid=%b pc=%h", k, ren2, addr2, valid2, pc2);
            imemload2 = mem(addr2);
            @(negedge CLK);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end for the pipelined successor of the single-cycle datapath. It owns the PC and drives the instruction side of datapath_cache_if (imemREN/imemaddr/imemload/ihit). It prefetches sequential words into a DEPTH-entry queue tagged with their PC, and presents them to decode under a valid/stall handshake. It flushes on branch/jump redirect and stops permanently on halt.

Parameters:
PC_INIT, 0, PC value loaded on reset.
WORD_W, 32, instruction/address width.
DEPTH, 4, prefetch queue entries; power of 2, >= 2.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  reset, synchronous, active-high.
imemREN  out  1  instruction read request.
imemaddr  out  WORD_W  fetch address; word aligned.
imemload  in  WORD_W  instruction data; valid when ihit.
ihit  in  1  request completed this cycle.
redirect  in  1  flush and restart fetch at redirect_pc.
redirect_pc  in  WORD_W  restart target; bits [1:0] ignored and forced to 0.
halt  in  1  stop fetching.
stall  in  1  decode cannot accept the head this cycle.
instr_valid  out  1  queue head valid.
instr  out  WORD_W  head instruction.
instr_pc  out  WORD_W  PC of head instruction; decode computes pc+4 from it.
q_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (RST high at an edge): state FETCH, fetch_pc = PC_INIT, queue empty, storage cleared. Outputs: imemREN 0, instr_valid 0, instr 0, instr_pc 0, q_count 0. RST overrides all other inputs and is honoured mid-request; an in-flight ihit in the reset cycle is dropped.
- States: FETCH, SQUASH, HALTED.
- FETCH:
  - A request starts when q_count < DEPTH. imemREN is 1 and imemaddr = fetch_pc.
  - Once started, the request is held with a stable address until ihit, even if the queue fills by pop accounting. Overflow cannot occur, because pops only reduce occupancy.
  - On ihit: push {imemload, fetch_pc}, then fetch_pc += 4, wrapping modulo 2^WORD_W.
  - Latency: ihit at cycle t gives instr_valid at t+1. There is no bypass.
- Pop: when instr_valid && !stall, at the clock edge. Push and pop in the same cycle leave q_count unchanged.
- Redirect (priority below RST and halt):
  - The queue is flushed, including any pop that cycle.
  - If no request is outstanding, or ihit is asserted that cycle: the ihit data is discarded, fetch_pc = redirect_pc, state stays FETCH, and the next request begins the following cycle.
  - If a request is outstanding without ihit: the target is stored and the state goes to SQUASH.
- SQUASH:
  - imemREN stays 1 with the old address until ihit. The returned data is discarded.
  - On ihit, fetch_pc = stored target and the state returns to FETCH.
  - A further redirect in SQUASH overwrites the stored target.
  - instr_valid is 0 throughout.
- HALTED:
  - Entered from any state on halt. imemREN is 0 from the next cycle.
  - An outstanding request is abandoned and its ihit ignored.
  - The queue is flushed and instr_valid is 0.
  - The only exit is RST.
- Halt and redirect in the same cycle: halt wins.
- Empty queue: instr_valid is 0, and instr/instr_pc hold their last values (don't care).

Optional Feature:
FETCH_PERF_EN:
- Defined: adds three output ports, each 32 bits and saturating, all cleared by RST:
  - perf_fetched: counts accepted pushes.
  - perf_squashed: counts ihit words discarded, plus queue entries flushed.
  - perf_qfull: counts cycles with q_count == DEPTH.
- Undefined: these ports and counters are absent, and the rest of the behaviour is identical.

Decomposition:
- cpu_types_pkg gains fetch_state_t (FETCH, SQUASH, HALTED) and fetch_entry_t (instr, pc).
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t with parameter DEPTH. It provides push, pop, flush, count, head and full/empty, with flush taking priority over push/pop.
- fetch_unit holds the FSM, fetch_pc and the stored redirect target.

Test Plan:
- Reset then ihit every cycle, stall = 0 -> imemaddr 0,4,8,...; instr_pc 0x0 at cycle 2, then +4 per cycle; q_count <= 1.
- stall = 1 held, ihit every cycle, DEPTH = 4 -> q_count 4; imemREN drops; release stall -> heads 0x0,0x4,0x8,0xC in order, fetch resumes at 0x10.
- Request outstanding at 0x8, redirect to 0x103, no ihit for 3 cycles -> state SQUASH, imemaddr stays 0x8; ihit discarded; next imemaddr 0x100; first instr_pc 0x100.
- redirect and ihit in the same cycle with pop pending -> queue empty the next cycle, data dropped, imemaddr = redirect_pc.
- halt with request outstanding -> imemREN 0 the next cycle, instr_valid 0, later ihit ignored; RST -> fetch restarts at PC_INIT.
- PC_INIT = 0xFFFFFFF8, run 3 fetches -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap).
